// File: rtl/reg_wb_queue.sv
// Write-back queue: buffers {addr,data} requests and drains one per cycle onto the reg16 write bus as one-hot ld + Din.
// Latency: an entry accepted at edge k into an empty queue drives ld during cycle k..k+1 and is written into reg16 at edge k+1.
// Backpressure: wb_ready drops when DEPTH entries are queued, with no pass-through even on a same-cycle pop; rf_stall holds the drain.
//
// Ports: clk/reset (sync, active-low); wb_valid/wb_ready/wb_addr/wb_data request side;
//        rf_stall, ld, Din register-file write bus; chk_addr/chk_hit/chk_data forwarding lookup;
//        count = occupied entries.
// Optional macro WB_ZERO_REG_EN: requests to register 0 are accepted but dropped, and lookups of 0 miss.

module reg_wb_queue #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wb_valid,
   output logic                         wb_ready,
   input  logic [ADDR_W-1:0]            wb_addr,
   input  logic [DATA_W-1:0]            wb_data,
   input  logic                         rf_stall,
   output logic [(1<<ADDR_W)-1:0]       ld,
   output logic [DATA_W-1:0]            Din,
   input  logic [ADDR_W-1:0]            chk_addr,
   output logic                         chk_hit,
   output logic [DATA_W-1:0]            chk_data,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] mem_addr [DEPTH];
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  lk_idx;

   logic push_acc;   // handshake completes
   logic push_store; // handshake completes and the entry is kept
   logic pop;
   logic keep;
   logic chk_en;

`ifdef WB_ZERO_REG_EN
   assign keep   = (wb_addr != '0);
   assign chk_en = (chk_addr != '0);
`else
   assign keep   = 1'b1;
   assign chk_en = 1'b1;
`endif

   assign wb_ready   = reset && (count != CNT_W'(DEPTH));
   assign push_acc   = wb_valid && wb_ready;
   assign push_store = push_acc && keep;
   // The head is only valid if it was stored before this edge, so an
   // empty queue never pops in the same cycle it is filled.
   assign pop        = reset && (count != '0) && !rf_stall;

   always_comb begin
      ld  = '0;
      Din = '0;
      if (pop) begin
         ld[mem_addr[rd_ptr]] = 1'b1;
         Din                  = mem_data[rd_ptr];
      end
   end

   // Walk oldest to newest so the last match left standing is the newest.
   // Uses pre-edge contents, so the entry popping this cycle still hits.
   always_comb begin
      chk_hit  = 1'b0;
      chk_data = '0;
      lk_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         lk_idx = rd_ptr + PTR_W'(i);
         if (chk_en && (CNT_W'(i) < count) && (mem_addr[lk_idx] == chk_addr)) begin
            chk_hit  = 1'b1;
            chk_data = mem_data[lk_idx];
         end
      end
   end

   // Entry storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push_store) begin
         mem_addr[wr_ptr] <= wb_addr;
         mem_data[wr_ptr] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_store) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push_store, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
